search_update_scheduler: RTL and testbench

Schedules access to the group lookup tables between the packet search stream and the rule-update stream. Packets go straight into the search pipeline. An insert, delete or modify command is only written once the pipeline has been drained, so no in-flight packet ever sees a half-updated rule. The block sits directly in front of the search-stage chain. It drives the packet tuple into stage 0 and the shared write port (we/addr/din) of the G0…G4/G4-other tables.

---
 rtl/search_update_scheduler.sv | 157 +++++++++++++++
 tb/tb_search_update_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/search_update_scheduler.sv
// Arbitrates the search-stage entry between packets and rule updates; updates wait for the
// pipeline to drain, then write once. Optional UPD_STATS_EN adds update/stall counters.
module search_update_scheduler #(
    parameter int unsigned INDEX_BIT_LEN    = 11,
    parameter int unsigned PACKET_BIT_LEN   = 104,
    parameter int unsigned COMMAND_BIT_LEN  = 2,
    parameter int unsigned ENTRY_BIT_LEN    = 60,
    parameter int unsigned PIPE_DEPTH       = 4,
    parameter int unsigned MAX_SEARCH_BURST = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pkt_valid,
    output logic                       pkt_ready,
    input  logic [PACKET_BIT_LEN-1:0]  pkt_tuple,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [COMMAND_BIT_LEN-1:0] upd_cmd,
    input  logic [2:0]                 upd_group,
    input  logic [INDEX_BIT_LEN-1:0]   upd_index,
    input  logic [ENTRY_BIT_LEN-1:0]   upd_data,
    output logic                       srch_valid,
    output logic [PACKET_BIT_LEN-1:0]  srch_tuple,
    output logic [5:0]                 tbl_we,
    output logic [INDEX_BIT_LEN-1:0]   tbl_addr,
    output logic [ENTRY_BIT_LEN-1:0]   tbl_din,
    output logic                       upd_done,
    output logic                       upd_err,
    output logic                       busy
`ifdef UPD_STATS_EN
    ,
    output logic [15:0]                stat_upd_cnt,
    output logic [15:0]                stat_stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StDrain, StWrite} state_e;

    localparam int unsigned BurstW =
        (MAX_SEARCH_BURST > 0) ? $clog2(MAX_SEARCH_BURST + 1) : 1;
    localparam logic [BurstW-1:0]          BurstMax  = BurstW'(MAX_SEARCH_BURST);
    localparam logic [3:0]                 DrainLoad = 4'(PIPE_DEPTH);
    localparam logic [COMMAND_BIT_LEN-1:0] CmdNop    = '0;
    localparam logic [COMMAND_BIT_LEN-1:0] CmdDelete = COMMAND_BIT_LEN'(2);

    state_e                     state_q, state_d;
    logic [BurstW-1:0]          burst_q;
    logic [3:0]                 drain_q;
    logic [COMMAND_BIT_LEN-1:0] cmd_q;
    logic [2:0]                 grp_q;
    logic [INDEX_BIT_LEN-1:0]   idx_q;
    logic [ENTRY_BIT_LEN-1:0]   data_q;

    logic grant, pkt_acc, upd_acc, upd_legal;

    // A waiting update only overrides packets once the burst allowance is used up.
    assign grant     = upd_valid && (!pkt_valid || burst_q == BurstMax);
    assign pkt_acc   = pkt_valid && pkt_ready;
    assign upd_acc   = upd_valid && upd_ready;
    assign upd_legal = (upd_cmd != CmdNop) && (upd_group < 3'd6);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (upd_acc && upd_legal) state_d = StDrain;
            StDrain: if (drain_q == 4'd1) state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pkt_ready = 1'b0;
        upd_ready = 1'b0;
        tbl_we    = '0;
        upd_done  = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy      = 1'b0;
                upd_ready = grant;
                pkt_ready = !grant;
            end
            StWrite: begin
                tbl_we   = 6'b000001 << grp_q;
                upd_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            srch_valid <= 1'b0;
            srch_tuple <= '0;
            burst_q    <= '0;
            drain_q    <= '0;
            cmd_q      <= '0;
            grp_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            tbl_addr   <= '0;
            tbl_din    <= '0;
            upd_err    <= 1'b0;
        end else begin
            srch_valid <= pkt_acc;
            if (pkt_acc) srch_tuple <= pkt_tuple;

            if (!upd_valid || upd_acc) begin
                burst_q <= '0;
            end else if (pkt_acc && burst_q != BurstMax) begin
                burst_q <= burst_q + 1'b1;
            end

            if (upd_acc && upd_legal) begin
                cmd_q   <= upd_cmd;
                grp_q   <= upd_group;
                idx_q   <= upd_index;
                data_q  <= upd_data;
                drain_q <= DrainLoad;
            end else if (state_q == StDrain) begin
                drain_q <= drain_q - 4'd1;
            end

            // Address/data are loaded on entry to WRITE and then held.
            if (state_q == StDrain && state_d == StWrite) begin
                tbl_addr <= idx_q;
                tbl_din  <= (cmd_q == CmdDelete) ? '0 : data_q;
            end

            upd_err <= upd_acc && !upd_legal;
        end
    end

`ifdef UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_upd_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (upd_done && stat_upd_cnt != 16'hFFFF) stat_upd_cnt <= stat_upd_cnt + 16'd1;
            if (pkt_valid && !pkt_ready && stat_stall_cnt != 16'hFFFF) begin
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_search_update_scheduler.sv
// Directed bench for search_update_scheduler with PIPE_DEPTH=4 and MAX_SEARCH_BURST=3.
module tb_search_update_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pkt_valid, pkt_ready;
    logic [103:0] pkt_tuple;
    logic         upd_valid, upd_ready;
    logic [1:0]   upd_cmd;
    logic [2:0]   upd_group;
    logic [10:0]  upd_index;
    logic [59:0]  upd_data;
    logic         srch_valid;
    logic [103:0] srch_tuple;
    logic [5:0]   tbl_we;
    logic [10:0]  tbl_addr;
    logic [59:0]  tbl_din;
    logic         upd_done, upd_err, busy;

    int n_total = 0;
    int n_pass  = 0;

    search_update_scheduler #(
        .PIPE_DEPTH       (4),
        .MAX_SEARCH_BURST (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_tuple  (pkt_tuple),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_cmd    (upd_cmd),
        .upd_group  (upd_group),
        .upd_index  (upd_index),
        .upd_data   (upd_data),
        .srch_valid (srch_valid),
        .srch_tuple (srch_tuple),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_din    (tbl_din),
        .upd_done   (upd_done),
        .upd_err    (upd_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept a legal update from idle, then follow it through drain and write.
    task automatic do_update(input logic [1:0] cmd, input logic [2:0] grp, input logic [10:0] idx,
                             input logic [59:0] data, input logic [5:0] exp_we,
                             input logic [59:0] exp_din);
        upd_cmd   = cmd;
        upd_group = grp;
        upd_index = idx;
        upd_data  = data;
        upd_valid = 1'b1;
        #1;
        chk("upd_ready_idle", upd_ready, 1);
        chk("pkt_ready_idle", pkt_ready, 0);
        tick();
        upd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_busy", busy, 1);
            chk("drain_we", tbl_we, 0);
            chk("drain_done", upd_done, 0);
            tick();
        end
        chk("write_we", tbl_we, exp_we);
        chk("write_addr", tbl_addr, idx);
        chk("write_din", tbl_din, exp_din);
        chk("write_done", upd_done, 1);
        chk("write_busy", busy, 1);
        tick();
        chk("post_we", tbl_we, 0);
        chk("post_done", upd_done, 0);
        chk("post_busy", busy, 0);
        chk("post_addr_hold", tbl_addr, idx);
        chk("post_din_hold", tbl_din, exp_din);
    endtask

    initial begin
        rst_n = 1'b0;
        pkt_valid = 1'b0;
        pkt_tuple = '0;
        upd_valid = 1'b0;
        upd_cmd = '0;
        upd_group = '0;
        upd_index = '0;
        upd_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_srch_valid", srch_valid, 0);
        chk("rst_srch_tuple", srch_tuple, 0);
        chk("rst_we", tbl_we, 0);
        chk("rst_addr", tbl_addr, 0);
        chk("rst_din", tbl_din, 0);
        chk("rst_done", upd_done, 0);
        chk("rst_err", upd_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_ready", pkt_ready, 1);
        chk("rst_upd_ready", upd_ready, 0);

        // Idle insert into G2
        do_update(2'b01, 3'd2, 11'h15, 60'hABC, 6'b000100, 60'hABC);

        // Delete in G4-other: data ignored, din cleared
        do_update(2'b10, 3'd5, 11'd7, '1, 6'b100000, 60'h0);

        // Back-to-back packet stream
        for (int i = 0; i < 10; i++) begin
            pkt_valid = 1'b1;
            pkt_tuple = 104'(i) * 104'h1_0001 + 104'hA000;
            #1;
            chk("stream_pkt_ready", pkt_ready, 1);
            tick();
            chk("stream_srch_valid", srch_valid, 1);
            chk("stream_srch_tuple", srch_tuple, 104'(i) * 104'h1_0001 + 104'hA000);
        end
        pkt_valid = 1'b0;
        tick();
        chk("stream_end_valid", srch_valid, 0);

        // Starvation limit: three packets, then the update wins
        pkt_valid = 1'b1;
        pkt_tuple = 104'hBEEF;
        upd_valid = 1'b1;
        upd_cmd   = 2'b11;
        upd_group = 3'd0;
        upd_index = 11'h3;
        upd_data  = 60'h55;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("starve_pkt_ready", pkt_ready, 1);
            chk("starve_upd_ready", upd_ready, 0);
            tick();
        end
        chk("starve_grant_upd", upd_ready, 1);
        chk("starve_grant_pkt", pkt_ready, 0);
        tick();
        upd_valid = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("starve_drain_pkt_ready", pkt_ready, 0);
            chk("starve_drain_srch_valid", srch_valid, 0);
            tick();
        end
        chk("starve_write_pkt_ready", pkt_ready, 0);
        chk("starve_write_we", tbl_we, 6'b000001);
        chk("starve_write_din", tbl_din, 60'h55);
        tick();
        chk("starve_resume_ready", pkt_ready, 1);
        tick();
        chk("starve_resume_valid", srch_valid, 1);
        pkt_valid = 1'b0;
        tick();

        // Illegal commands: group 6, then NOP
        for (int j = 0; j < 2; j++) begin
            upd_cmd   = (j == 0) ? 2'b01 : 2'b00;
            upd_group = (j == 0) ? 3'd6 : 3'd0;
            upd_valid = 1'b1;
            #1;
            chk("illegal_upd_ready", upd_ready, 1);
            tick();
            upd_valid = 1'b0;
            chk("illegal_err", upd_err, 1);
            chk("illegal_busy", busy, 0);
            chk("illegal_we", tbl_we, 0);
            tick();
            chk("illegal_err_clear", upd_err, 0);
            chk("illegal_busy2", busy, 0);
        end

        // Reset during drain discards the update
        upd_cmd   = 2'b01;
        upd_group = 3'd1;
        upd_index = 11'h2A;
        upd_data  = 60'h123;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", tbl_we, 0);
        chk("mid_rst_done", upd_done, 0);
        chk("mid_rst_addr", tbl_addr, 0);
        chk("mid_rst_din", tbl_din, 0);
        chk("mid_rst_srch_valid", srch_valid, 0);
        chk("mid_rst_err", upd_err, 0);
        for (int k = 0; k < 6; k++) begin
            chk("mid_rst_no_we", tbl_we, 0);
            chk("mid_rst_no_done", upd_done, 0);
            tick();
        end
        do_update(2'b01, 3'd1, 11'h2A, 60'h123, 6'b000010, 60'h123);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
